// File: rtl/ring_counter_checker.sv
// ---------------------------------------------------------------------------
// ring_counter_checker
//
// Receive-side monitor for a one-hot ring counter bus. Each enabled cycle the
// WIDTH-bit pattern on q_in is sampled. The block then:
//   - decodes the pattern to a binary index,
//   - checks that it is a one-position rotate-left of the last accepted
//     sample,
//   - runs a HUNT -> SYNC -> LOCKED acquisition state machine,
//   - reports sequence breaks seen while LOCKED (pulse plus saturating
//     count) and wraps back to bit 0.
//
// Parameters
//   WIDTH    : ring width in bits (>= 2)
//   LOCK_CNT : consecutive correct rotations needed to reach LOCKED (>= 1)
//   ERR_W    : width of the saturating error counter
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset; overrides every other input
//   en         : sample enable; when low, all state holds and pulses are 0
//   q_in       : ring pattern under observation
//   idx        : binary position of the set bit in the last valid sample
//   onehot_ok  : the last enabled sample had exactly one bit set
//   locked     : state machine is in LOCKED
//   err_pulse  : one-cycle pulse on a sequence break while LOCKED
//   wrap_pulse : one-cycle pulse on a correct LOCKED step into bit 0
//   err_count  : LOCKED sequence breaks, saturating at all-ones
//
// Every output is registered, so a sample taken at edge N shows up right
// after edge N.
// ---------------------------------------------------------------------------
module ring_counter_checker #(
  parameter  int WIDTH    = 4,
  parameter  int LOCK_CNT = 3,
  parameter  int ERR_W    = 8,
  localparam int IDX_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] q_in,
  output logic [IDX_W-1:0] idx,
  output logic             onehot_ok,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count
);

  // The streak must be able to hold LOCK_CNT, the value it reaches on the
  // edge that enters LOCKED.
  localparam int STREAK_W = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  // A pattern is one-hot when it is non-zero and clearing its lowest set bit
  // leaves nothing behind.
  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  // OR-reduction encoder. The result is only used when the input is one-hot,
  // so multi-hot inputs need no priority handling.
  function automatic logic [IDX_W-1:0] encode(input logic [WIDTH-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) r = r | IDX_W'(i);
    end
    return r;
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t              state_q,      state_d;
  logic [STREAK_W-1:0] streak_q,     streak_d;
  logic [WIDTH-1:0]    prev_q,       prev_d;
  logic [IDX_W-1:0]    idx_q,        idx_d;
  logic                onehot_ok_q,  onehot_ok_d;
  logic                locked_q,     locked_d;
  logic                err_pulse_q,  err_pulse_d;
  logic                wrap_pulse_q, wrap_pulse_d;
  logic [ERR_W-1:0]    err_count_q,  err_count_d;

  // -------------------------------------------------------------------------
  // Sample qualification
  // -------------------------------------------------------------------------
  logic             sample_onehot;
  logic             sample_valid;
  logic             sample_match;
  logic [WIDTH-1:0] exp_pat;
  logic [STREAK_W-1:0] streak_inc;

  assign sample_onehot = is_onehot(q_in);
  assign sample_valid  = en && sample_onehot;
  // After reset prev is all-zero, so exp is all-zero too and can never equal
  // a valid sample; the first valid sample only matters through HUNT.
  assign exp_pat       = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
  assign sample_match  = sample_valid && (q_in == exp_pat);
  assign streak_inc    = streak_q + STREAK_W'(1);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    prev_d       = prev_q;
    idx_d        = idx_q;
    onehot_ok_d  = onehot_ok_q;
    err_count_d  = err_count_q;
    err_pulse_d  = 1'b0;
    wrap_pulse_d = 1'b0;

    if (en) begin
      onehot_ok_d = sample_onehot;
      // idx follows every valid sample, including one that breaks LOCKED.
      if (sample_onehot) idx_d = encode(q_in);

      unique case (state_q)
        ST_HUNT: begin
          if (sample_valid) begin
            prev_d   = q_in;
            streak_d = '0;
            state_d  = ST_SYNC;
          end
        end

        ST_SYNC: begin
          if (sample_match) begin
            prev_d   = q_in;
            streak_d = streak_inc;
            if (streak_inc == STREAK_W'(LOCK_CNT)) state_d = ST_LOCKED;
          end else if (sample_valid) begin
            // Valid but out of sequence: treat it as a fresh starting point.
            prev_d   = q_in;
            streak_d = '0;
          end else begin
            streak_d = '0;
            state_d  = ST_HUNT;
          end
        end

        ST_LOCKED: begin
          if (sample_match) begin
            prev_d       = q_in;
            wrap_pulse_d = q_in[0];
          end else begin
            // The breaking sample is not trusted as a phase reference, so
            // prev is left alone; HUNT reloads it from the next valid sample.
            err_pulse_d = 1'b1;
            if (err_count_q != {ERR_W{1'b1}}) err_count_d = err_count_q + ERR_W'(1);
            streak_d = '0;
            state_d  = ST_HUNT;
          end
        end

        default: begin
          streak_d = '0;
          state_d  = ST_HUNT;
        end
      endcase
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HUNT;
      streak_q     <= '0;
      prev_q       <= '0;
      idx_q        <= '0;
      onehot_ok_q  <= 1'b0;
      locked_q     <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_pulse_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      prev_q       <= prev_d;
      idx_q        <= idx_d;
      onehot_ok_q  <= onehot_ok_d;
      locked_q     <= locked_d;
      err_pulse_q  <= err_pulse_d;
      wrap_pulse_q <= wrap_pulse_d;
      err_count_q  <= err_count_d;
    end
  end

  assign idx        = idx_q;
  assign onehot_ok  = onehot_ok_q;
  assign locked     = locked_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_pulse = wrap_pulse_q;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_ring_counter_checker.sv
// ---------------------------------------------------------------------------
// tb_ring_counter_checker
//
// Each driven cycle is fed to a reference model that tracks the ring phase as
// an integer position. The model's expected outputs go into a scoreboard
// queue; a monitor pops one entry after every rising edge and compares it
// with the DUT outputs. A small error counter (ERR_W=2) is used so that
// saturation is reachable.
// ---------------------------------------------------------------------------
module tb_ring_counter_checker;

  localparam int W  = 4;
  localparam int LC = 3;
  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [W-1:0]  q_in = '0;
  logic [1:0]    idx;
  logic          onehot_ok, locked, err_pulse, wrap_pulse;
  logic [EW-1:0] err_count;

  ring_counter_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(EW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .q_in       (q_in),
    .idx        (idx),
    .onehot_ok  (onehot_ok),
    .locked     (locked),
    .err_pulse  (err_pulse),
    .wrap_pulse (wrap_pulse),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx, ok, lk, ep, wp, cnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state: mode 0=hunt 1=sync 2=locked; prev is the ring
  // position of the last accepted sample, -1 when none.
  int m_mode = 0, m_run = 0, m_prev = -1, m_idx = 0, m_ok = 0, m_cnt = 0;
  int m_ep = 0, m_wp = 0;

  task automatic model_step(input bit r, input bit e, input logic [W-1:0] q);
    int   pos;
    bit   valid, good;
    exp_t x;
    if (r) begin
      m_mode = 0; m_run = 0; m_prev = -1; m_idx = 0; m_ok = 0;
      m_cnt = 0;  m_ep = 0;  m_wp = 0;
    end else begin
      m_ep = 0; m_wp = 0;
      if (e) begin
        valid = ($countones(q) == 1);
        pos = -1;
        if (valid) begin
          pos = 0;
          while ((q >> pos) != 1) pos++;
        end
        good = valid && (m_prev >= 0) && (pos == (m_prev + 1) % W);
        m_ok = valid ? 1 : 0;
        if (valid) m_idx = pos;
        case (m_mode)
          0: if (valid) begin m_prev = pos; m_run = 0; m_mode = 1; end
          1: begin
            if (good) begin
              m_prev = pos; m_run++;
              if (m_run == LC) m_mode = 2;
            end else if (valid) begin
              m_prev = pos; m_run = 0;
            end else begin
              m_run = 0; m_mode = 0;
            end
          end
          default: begin
            if (good) begin
              m_prev = pos;
              m_wp = (pos == 0) ? 1 : 0;
            end else begin
              m_ep = 1;
              if (m_cnt < (1 << EW) - 1) m_cnt++;
              m_run = 0; m_mode = 0;
            end
          end
        endcase
      end
    end
    x.idx = m_idx; x.ok = m_ok; x.lk = (m_mode == 2) ? 1 : 0;
    x.ep = m_ep;   x.wp = m_wp; x.cnt = m_cnt;
    sb.push_back(x);
  endtask

  task automatic drive(input bit r, input bit e, input logic [W-1:0] q);
    @(negedge clk);
    rst = r; en = e; q_in = q;
    model_step(r, e, q);
  endtask

  // Next correct pattern according to the model's phase.
  function automatic logic [W-1:0] nxt();
    logic [W-1:0] one;
    int p;
    one = 1;
    p = (m_prev < 0) ? 0 : (m_prev + 1) % W;
    return one << p;
  endfunction

  task automatic good_steps(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b1, nxt());
  endtask

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a registered result after every rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        x = sb.pop_front();
        check("idx",        int'(idx),        x.idx);
        check("onehot_ok",  int'(onehot_ok),  x.ok);
        check("locked",     int'(locked),     x.lk);
        check("err_pulse",  int'(err_pulse),  x.ep);
        check("wrap_pulse", int'(wrap_pulse), x.wp);
        check("err_count",  int'(err_count),  x.cnt);
      end
    end
  end

  initial begin
    int kind;
    int budget;
    logic [W-1:0] one;
    one = 1;

    // Reset, then the golden lock sequence with one wrap.
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 4'b0001);
    drive(1'b0, 1'b1, 4'b0010);
    drive(1'b0, 1'b1, 4'b0100);
    drive(1'b0, 1'b1, 4'b1000);
    drive(1'b0, 1'b1, 4'b0001);

    // Break while LOCKED (0100 instead of 0010), then relock.
    drive(1'b0, 1'b1, 4'b0100);
    drive(1'b0, 1'b1, 4'b1000);
    drive(1'b0, 1'b1, 4'b0001);
    drive(1'b0, 1'b1, 4'b0010);
    drive(1'b0, 1'b1, 4'b0100);

    // Invalid patterns: one breaks LOCKED, the rest hit HUNT and SYNC.
    drive(1'b0, 1'b1, 4'b0000);
    drive(1'b0, 1'b1, 4'b0110);
    drive(1'b0, 1'b1, 4'b1111);
    drive(1'b0, 1'b1, 4'b0001); drive(1'b0, 1'b1, 4'b0110);
    drive(1'b0, 1'b1, 4'b0001); drive(1'b0, 1'b1, 4'b0000);
    drive(1'b0, 1'b1, 4'b0001); drive(1'b0, 1'b1, 4'b1111);

    // Enable gating while LOCKED at 0010.
    drive(1'b0, 1'b1, 4'b0001);
    drive(1'b0, 1'b1, 4'b0010);
    drive(1'b0, 1'b1, 4'b0100);
    drive(1'b0, 1'b1, 4'b1000);
    drive(1'b0, 1'b1, 4'b0001);
    drive(1'b0, 1'b1, 4'b0010);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, W'($urandom));
    drive(1'b0, 1'b1, 4'b0100);

    // Saturation: five LOCKED breaks after a clean reset.
    drive(1'b1, 1'b0, '0);
    for (int k = 0; k < 5; k++) begin
      good_steps(LC + 1);
      drive(1'b0, 1'b1, 4'b0011);
    end

    // Reset while LOCKED with err_count=2, with en also high.
    drive(1'b1, 1'b0, '0);
    for (int k = 0; k < 2; k++) begin
      good_steps(LC + 1);
      drive(1'b0, 1'b1, 4'b1001);
    end
    good_steps(LC + 1);
    drive(1'b1, 1'b1, nxt());
    good_steps(LC + 2);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      kind = $urandom_range(0, 9);
      if ($urandom_range(0, 199) == 0)
        drive(1'b1, 1'($urandom), W'($urandom));
      else if (kind < 6)
        drive(1'b0, ($urandom_range(0, 7) != 0), nxt());
      else if (kind < 8)
        drive(1'b0, ($urandom_range(0, 7) != 0), one << $urandom_range(0, W - 1));
      else
        drive(1'b0, ($urandom_range(0, 7) != 0), W'($urandom));
    end
    drive(1'b0, 1'b0, '0);

    // Let the monitor drain the scoreboard, bounded.
    budget = 10;
    while (sb.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
